// File: rtl/bcd_timer_ctrl.sv
// Four-digit BCD up/down timer with a prescaled step, pause/resume, load and clear.
// Every output comes straight from a register; done/ovf are single-cycle pulses.
module bcd_timer_ctrl #(
   parameter int unsigned TICK_DIV = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        pause,
   input  logic        clear,
   input  logic        ld,
   input  logic        up_dn,
   input  logic [15:0] d_in,
   output logic [15:0] digits,
   output logic [1:0]  state,
   output logic        done,
   output logic        ovf
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam int unsigned   PW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

   state_t        state_q, state_d;
   logic [15:0]   digits_q, digits_d;
   logic [PW-1:0] pre_q, pre_d;
   logic          dir_q, dir_d;
   logic          done_q, done_d;
   logic          ovf_q, ovf_d;

   logic [15:0]   clamp_val;
   logic [15:0]   inc_val;
   logic [15:0]   dec_val;
   logic          carry;
   logic          borrow;

   // Load value with each nibble saturated to 9 so digits stay valid BCD.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_clamp
         assign clamp_val[4*gi +: 4] = (d_in[4*gi +: 4] > 4'd9) ? 4'd9 : d_in[4*gi +: 4];
      end
   endgenerate

   // Ripple BCD increment/decrement; carry out of the top nibble marks 9999->0000.
   always_comb begin
      inc_val = digits_q;
      dec_val = digits_q;
      carry   = 1'b1;
      borrow  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (digits_q[4*i +: 4] == 4'd9) begin
               inc_val[4*i +: 4] = 4'd0;
            end else begin
               inc_val[4*i +: 4] = digits_q[4*i +: 4] + 4'd1;
               carry = 1'b0;
            end
         end
         if (borrow) begin
            if (digits_q[4*i +: 4] == 4'd0) begin
               dec_val[4*i +: 4] = 4'd9;
            end else begin
               dec_val[4*i +: 4] = digits_q[4*i +: 4] - 4'd1;
               borrow = 1'b0;
            end
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      digits_d = digits_q;
      pre_d    = pre_q;
      dir_d    = dir_q;
      done_d   = 1'b0;
      ovf_d    = 1'b0;
      if (clear) begin
         state_d  = IDLE;
         digits_d = '0;
         pre_d    = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (ld) begin
                  digits_d = clamp_val;
               end else if (!pause && start) begin
                  dir_d = up_dn;
                  pre_d = '0;
                  if (up_dn && digits_q == 16'd0) begin
                     state_d = DONE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = RUN;
                  end
               end
            end
            RUN: begin
               // Pause outranks the step, so a pause on a step edge freezes everything.
               if (pause) begin
                  state_d = PAUSED;
               end else if (pre_q == PRE_LAST) begin
                  pre_d = '0;
                  if (!dir_q) begin
                     digits_d = inc_val;
                     ovf_d    = carry;
                  end else begin
                     digits_d = dec_val;
                     if (dec_val == 16'd0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                     end
                  end
               end else begin
                  pre_d = pre_q + 1'b1;
               end
            end
            PAUSED: begin
               if (!pause && start) begin
                  state_d = RUN;
               end
            end
            DONE: begin
               if (ld) begin
                  digits_d = clamp_val;
                  state_d  = IDLE;
               end else if (!pause && start) begin
                  state_d = IDLE;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         digits_q <= '0;
         pre_q    <= '0;
         dir_q    <= 1'b0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         digits_q <= digits_d;
         pre_q    <= pre_d;
         dir_q    <= dir_d;
         done_q   <= done_d;
         ovf_q    <= ovf_d;
      end
   end

   assign digits = digits_q;
   assign state  = state_q;
   assign done   = done_q;
   assign ovf    = ovf_q;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Directed bench for bcd_timer_ctrl: a decimal-integer reference model checked every
// cycle, plus hand-computed literal checkpoints along each scenario.
module tb_bcd_timer_ctrl;

   localparam int TD = 4;
   localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSED = 2'd2, S_DONE = 2'd3;

   logic        clk = 1'b0;
   logic        reset, start, pause, clear, ld, up_dn;
   logic [15:0] d_in;
   logic [15:0] digits;
   logic [1:0]  state;
   logic        done, ovf;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 0;

   bcd_timer_ctrl #(.TICK_DIV(TD)) dut (
      .clk(clk), .reset(reset), .start(start), .pause(pause), .clear(clear),
      .ld(ld), .up_dn(up_dn), .d_in(d_in), .digits(digits), .state(state),
      .done(done), .ovf(ovf)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] st;
      int         cnt;
      int         pre;
      logic       dir;
      logic       done;
      logic       ovf;
   } mdl_t;

   mdl_t m;

   function automatic int clamp_dec(input logic [15:0] v);
      int r = 0;
      for (int i = 3; i >= 0; i--) begin
         int n = int'(v[4*i +: 4]);
         r = r * 10 + ((n > 9) ? 9 : n);
      end
      return r;
   endfunction

   function automatic logic [15:0] to_bcd(input int c);
      return {4'((c / 1000) % 10), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
   endfunction

   function automatic mdl_t mnext(input mdl_t c, input logic rst, input logic clr,
                                  input logic l, input logic pz, input logic st,
                                  input logic ud, input logic [15:0] din);
      mdl_t n = c;
      n.done = 1'b0;
      n.ovf  = 1'b0;
      if (rst) begin
         n = '{st: S_IDLE, cnt: 0, pre: 0, dir: 1'b0, done: 1'b0, ovf: 1'b0};
      end else if (clr) begin
         n.st = S_IDLE; n.cnt = 0; n.pre = 0;
      end else begin
         case (c.st)
            S_IDLE: begin
               if (l) n.cnt = clamp_dec(din);
               else if (!pz && st) begin
                  n.dir = ud;
                  n.pre = 0;
                  if (ud && c.cnt == 0) begin n.st = S_DONE; n.done = 1'b1; end
                  else n.st = S_RUN;
               end
            end
            S_RUN: begin
               if (pz) n.st = S_PAUSED;
               else if (c.pre == TD - 1) begin
                  n.pre = 0;
                  if (!c.dir) begin
                     if (c.cnt == 9999) begin n.cnt = 0; n.ovf = 1'b1; end
                     else n.cnt = c.cnt + 1;
                  end else begin
                     n.cnt = (c.cnt == 0) ? 9999 : c.cnt - 1;
                     if (n.cnt == 0) begin n.st = S_DONE; n.done = 1'b1; end
                  end
               end else n.pre = c.pre + 1;
            end
            S_PAUSED: if (!pz && st) n.st = S_RUN;
            default: begin
               if (l) begin n.cnt = clamp_dec(din); n.st = S_IDLE; end
               else if (!pz && st) n.st = S_IDLE;
            end
         endcase
      end
      return n;
   endfunction

   always @(posedge clk) m <= mnext(m, reset, clear, ld, pause, start, up_dn, d_in);

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            check("model digits", digits, to_bcd(m.cnt));
            check("model state", {14'd0, state}, {14'd0, m.st});
            check("model done", {15'd0, done}, {15'd0, m.done});
            check("model ovf", {15'd0, ovf}, {15'd0, m.ovf});
            check("done_ovf_excl", {15'd0, done & ovf}, 16'd0);
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_ld(input logic [15:0] v);
      ld = 1'b1; d_in = v; cyc(1); ld = 1'b0;
   endtask

   task automatic do_start(input logic dir);
      start = 1'b1; up_dn = dir; cyc(1); start = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1; cyc(1); clear = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; pause = 1'b0; clear = 1'b0; ld = 1'b0;
      up_dn = 1'b0; d_in = 16'h0;
      cyc(1);
      chk_en = 1'b1;
      check("reset digits", digits, 16'h0000);
      check("reset state", {14'd0, state}, 16'd0);
      reset = 1'b0;
      cyc(3);
      check("no autostart", {14'd0, state}, 16'd0);
      $display("txn reset: digits=%h state=%0d", digits, state);

      do_ld(16'h0003);
      check("ld 0003", digits, 16'h0003);
      do_start(1'b1);
      check("run entered", {14'd0, state}, {14'd0, S_RUN});
      cyc(3);
      check("no early step", digits, 16'h0003);
      cyc(1);
      check("down edge4", digits, 16'h0002);
      cyc(4);
      check("down edge8", digits, 16'h0001);
      cyc(4);
      check("down edge12", digits, 16'h0000);
      check("done pulse", {15'd0, done}, 16'd1);
      check("done state", {14'd0, state}, {14'd0, S_DONE});
      cyc(1);
      check("done one cycle", {15'd0, done}, 16'd0);
      do_start(1'b0);
      check("done->idle", {14'd0, state}, 16'd0);
      $display("txn countdown 0003: digits=%h state=%0d", digits, state);

      do_ld(16'h9998);
      do_start(1'b0);
      cyc(4);
      check("up 9999", digits, 16'h9999);
      cyc(4);
      check("wrap 0000", digits, 16'h0000);
      check("ovf pulse", {15'd0, ovf}, 16'd1);
      check("run after wrap", {14'd0, state}, {14'd0, S_RUN});
      cyc(1);
      check("ovf one cycle", {15'd0, ovf}, 16'd0);
      cyc(3);
      check("up after wrap", digits, 16'h0001);
      do_clear();
      $display("txn wrap 9998: digits=%h state=%0d", digits, state);

      do_ld(16'h0100);
      do_start(1'b1);
      cyc(4);
      check("borrow ripple", digits, 16'h0099);
      ld = 1'b1; d_in = 16'h1234; up_dn = 1'b0; cyc(1); ld = 1'b0;
      check("ld ignored run", digits, 16'h0099);
      cyc(3);
      check("dir held", digits, 16'h0098);
      do_clear();
      do_ld(16'h0A5F);
      check("clamp", digits, 16'h0959);
      $display("txn borrow/clamp: digits=%h state=%0d", digits, state);

      do_start(1'b0);
      cyc(3);
      pause = 1'b1; cyc(1);
      check("pause wins", digits, 16'h0959);
      check("paused", {14'd0, state}, {14'd0, S_PAUSED});
      cyc(3);
      check("pause hold", digits, 16'h0959);
      pause = 1'b0; start = 1'b1; cyc(1); start = 1'b0;
      check("resume", {14'd0, state}, {14'd0, S_RUN});
      check("resume no step", digits, 16'h0959);
      cyc(1);
      check("resume step", digits, 16'h0960);
      cyc(4);
      check("next step", digits, 16'h0961);
      $display("txn pause/resume: digits=%h state=%0d", digits, state);

      do_clear();
      do_start(1'b1);
      check("zero down done", {14'd0, state}, {14'd0, S_DONE});
      check("zero down pulse", {15'd0, done}, 16'd1);
      check("zero down digits", digits, 16'h0000);
      cyc(1);
      check("zero done low", {15'd0, done}, 16'd0);
      do_start(1'b0);
      $display("txn zero-down: digits=%h state=%0d", digits, state);

      do_ld(16'h0040);
      do_start(1'b0);
      cyc(8);
      check("at 0042", digits, 16'h0042);
      cyc(2);
      reset = 1'b1; cyc(1); reset = 1'b0;
      check("mid reset digits", digits, 16'h0000);
      check("mid reset state", {14'd0, state}, 16'd0);
      check("mid reset flags", {14'd0, done, ovf}, 16'd0);
      cyc(6);
      check("reset needs start", {14'd0, state}, 16'd0);
      do_ld(16'h0040);
      do_start(1'b0);
      cyc(8);
      check("at 0042 again", digits, 16'h0042);
      do_clear();
      check("mid clear digits", digits, 16'h0000);
      check("mid clear state", {14'd0, state}, 16'd0);
      cyc(6);
      check("clear needs start", digits, 16'h0000);
      do_start(1'b0);
      check("restart", {14'd0, state}, {14'd0, S_RUN});
      cyc(5);
      $display("txn reset/clear mid-run: digits=%h state=%0d", digits, state);

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
